// File: rtl/spi_sensor_resp_pkg.sv
// Shared definitions for the SPI sensor responder: register-map constants,
// FSM state encoding, command-byte layout and the auto-increment helper.
package spi_sensor_resp_pkg;

    // Identity register
    localparam logic [5:0] WHOAMI_ADDR = 6'h0F;
    localparam logic [7:0] WHOAMI_VAL  = 8'h33;

    // Sample registers (X/Y/Z low/high) preloaded through the local port
    localparam logic [5:0] OUT_X_L = 6'h28;
    localparam logic [5:0] OUT_X_H = 6'h29;
    localparam logic [5:0] OUT_Y_L = 6'h2A;
    localparam logic [5:0] OUT_Y_H = 6'h2B;
    localparam logic [5:0] OUT_Z_L = 6'h2C;
    localparam logic [5:0] OUT_Z_H = 6'h2D;

    // Command byte bit positions
    localparam int CMD_RNW = 7;
    localparam int CMD_MS  = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Field order matches CMD_RNW / CMD_MS above
    typedef struct packed {
        logic       rnw;
        logic       ms;
        logic [5:0] addr;
    } cmd_t;

    // Address step after each data byte; 6-bit arithmetic wraps 63 -> 0
    function automatic logic [5:0] next_addr(input logic [5:0] a, input logic ms);
        return a + {5'd0, ms};
    endfunction

endpackage

// File: rtl/spi_sensor_resp_if.sv
// Bus bundle for the SPI sensor responder.
//   SPI pins : spi_sck, spi_csn, spi_mosi (to responder), spi_miso, spi_miso_oe
//   Local    : loc_we, loc_addr, loc_wdata (to responder), loc_rdata
//   Status   : spi_wr/spi_waddr/spi_wdata write notification, busy
// slave  = responder side, master = SPI master / surrounding logic side.
interface spi_sensor_resp_if;
    import spi_sensor_resp_pkg::*;

    logic       spi_sck;
    logic       spi_csn;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic       loc_we;
    logic [5:0] loc_addr;
    logic [7:0] loc_wdata;
    logic [7:0] loc_rdata;
    logic       spi_wr;
    logic [5:0] spi_waddr;
    logic [7:0] spi_wdata;
    logic       busy;

    modport slave (
        input  spi_sck, spi_csn, spi_mosi, loc_we, loc_addr, loc_wdata,
        output spi_miso, spi_miso_oe, loc_rdata, spi_wr, spi_waddr, spi_wdata, busy
    );

    modport master (
        output spi_sck, spi_csn, spi_mosi, loc_we, loc_addr, loc_wdata,
        input  spi_miso, spi_miso_oe, loc_rdata, spi_wr, spi_waddr, spi_wdata, busy
    );

endinterface

// File: rtl/spi_sensor_resp_spi_sync.sv
// spi_sync: 2-flop synchronizer for an asynchronous pin plus single-cycle
// rise/fall pulses derived from the synchronized level.
//   clk, reset : system clock, async active-high reset
//   d          : asynchronous input pin
//   rise, fall : one-cycle pulses, valid 2 clk after the pin edge
module spi_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic meta, sync, prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_sensor_resp.sv
// spi_sensor_resp: SPI mode-3 responder emulating a 3-axis sensor register map.
// Oversamples sck/csn/mosi in the clk domain, decodes a command byte
// (rnw, ms, addr) followed by data bytes with optional auto-increment.
//   clk, reset : system clock, async active-high reset
//   bus        : spi_sensor_resp_if.slave (SPI pins, local port, write notify, busy)
module spi_sensor_resp
    import spi_sensor_resp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    spi_sensor_resp_if.slave  bus
);
    logic       sck_rise, sck_fall, csn_rise, csn_fall;
    logic       mosi_meta, mosi_s;
    state_t     state, state_nxt;
    logic [2:0] bit_cnt;
    logic [7:0] rx_sh, tx_sh;
    cmd_t       cmd;
    logic       miso_r, wr_r;
    logic [5:0] waddr_r;
    logic [7:0] wdata_r, rdata_r;
    logic [7:0] regs [64];

    // Comb strobes / outputs
    logic       active;
    logic       cmd_done, byte_done, tx_fall, spi_commit;
    logic [7:0] byte_in, rd_val;

    // sck idles high. csn resets to the asserted level on purpose: if the
    // master is still holding csn low when reset releases, no falling edge is
    // seen and the responder waits for a fresh select.
    spi_sync #(.RST_VAL(1'b1)) u_sck_sync (
        .clk(clk), .reset(reset), .d(bus.spi_sck), .rise(sck_rise), .fall(sck_fall));
    spi_sync #(.RST_VAL(1'b0)) u_csn_sync (
        .clk(clk), .reset(reset), .d(bus.spi_csn), .rise(csn_rise), .fall(csn_fall));

    // mosi only needs a level; its 2-flop delay lines up with sck's edge pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            mosi_meta <= bus.spi_mosi;
            mosi_s    <= mosi_meta;
        end
    end

    function automatic logic [7:0] reg_rd(input logic [5:0] a);
        return (a == WHOAMI_ADDR) ? WHOAMI_VAL : regs[a];
    endfunction

    assign byte_in = {rx_sh[6:0], mosi_s};
    assign rd_val  = reg_rd(cmd.addr);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (csn_fall) state_nxt = ST_CMD;
            ST_CMD: begin
                if (csn_rise)                           state_nxt = ST_IDLE;
                else if (sck_rise && bit_cnt == 3'd7)   state_nxt = ST_DATA;
            end
            ST_DATA: if (csn_rise) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / strobes ----------------
    // csn_rise overrides everything so a partial byte never commits.
    always_comb begin
        active     = (state != ST_IDLE);
        cmd_done   = (state == ST_CMD)  && sck_rise && (bit_cnt == 3'd7) && !csn_rise;
        byte_done  = (state == ST_DATA) && sck_rise && (bit_cnt == 3'd7) && !csn_rise;
        tx_fall    = (state == ST_DATA) && cmd.rnw && sck_fall && !csn_rise;
        spi_commit = byte_done && !cmd.rnw && (cmd.addr != WHOAMI_ADDR);
    end

    // ---------------- shift / command datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= 3'd0;
            rx_sh   <= 8'h00;
            tx_sh   <= 8'h00;
            cmd     <= '0;
            miso_r  <= 1'b0;
            wr_r    <= 1'b0;
            waddr_r <= 6'h00;
            wdata_r <= 8'h00;
        end else begin
            wr_r <= 1'b0;
            if (csn_rise || (state == ST_IDLE && csn_fall)) begin
                bit_cnt <= 3'd0;
                miso_r  <= 1'b0;
            end else if (state != ST_IDLE && sck_rise) begin
                rx_sh   <= byte_in;
                bit_cnt <= bit_cnt + 3'd1;   // wraps 7 -> 0 at byte end
                if (cmd_done)
                    cmd <= byte_in;
                if (byte_done) begin
                    if (!cmd.rnw) begin
                        wr_r    <= 1'b1;     // WHOAMI writes still notify
                        waddr_r <= cmd.addr;
                        wdata_r <= byte_in;
                    end
                    cmd.addr <= next_addr(cmd.addr, cmd.ms);
                end
            end else if (tx_fall) begin
                // First falling edge of a byte snapshots the register so a
                // local write mid-byte cannot tear the outgoing value.
                if (bit_cnt == 3'd0) begin
                    miso_r <= rd_val[7];
                    tx_sh  <= {rd_val[6:0], 1'b0};
                end else begin
                    miso_r <= tx_sh[7];
                    tx_sh  <= {tx_sh[6:0], 1'b0};
                end
            end
        end
    end

    // ---------------- register file + local read ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) regs[i] <= 8'h00;
            rdata_r <= 8'h00;
        end else begin
            rdata_r <= reg_rd(bus.loc_addr);
            if (bus.loc_we && bus.loc_addr != WHOAMI_ADDR)
                regs[bus.loc_addr] <= bus.loc_wdata;
            // Later assignment wins: SPI beats a same-cycle local write
            if (spi_commit)
                regs[cmd.addr] <= byte_in;
        end
    end

    assign bus.spi_miso    = miso_r;
    assign bus.spi_miso_oe = active;
    assign bus.busy        = active;
    assign bus.spi_wr      = wr_r;
    assign bus.spi_waddr   = waddr_r;
    assign bus.spi_wdata   = wdata_r;
    assign bus.loc_rdata   = rdata_r;

endmodule
